// File: rtl/fft_result_streamer.sv
// Streams a finished FFT frame out of the working RAM as valid/ready bins.
// The read credit covers the one in-flight RAM read, so the 2-entry output FIFO cannot overflow.
module fft_result_streamer #(
  parameter int DATA_WIDTH    = 48,
  parameter int BUFFER_DEPTH  = 512,
  parameter int ADDR_WIDTH    = 9,
  parameter int BIT_REVERSE   = 1,
  parameter int HALF_SPECTRUM = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_start,
  output logic [ADDR_WIDTH-1:0]   o_ram_addr,
  output logic                    o_ram_wr_en,
  output logic [DATA_WIDTH-1:0]   o_ram_data,
  input  logic [DATA_WIDTH-1:0]   i_ram_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [DATA_WIDTH/2-1:0] o_real,
  output logic [DATA_WIDTH/2-1:0] o_imag,
  output logic [ADDR_WIDTH-1:0]   o_index,
  output logic                    o_last,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int HALF_W = DATA_WIDTH / 2;
  localparam int NB     = (HALF_SPECTRUM != 0) ? BUFFER_DEPTH / 2 : BUFFER_DEPTH;
  localparam int CW     = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         NB_C     = CW'(NB);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NB - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           rd_idx_q;
  logic                    inflight_q;
  logic [ADDR_WIDTH-1:0]   infl_idx_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [1:0]              count_q;
  logic [DATA_WIDTH-1:0]   data0_q, data1_q;
  logic [ADDR_WIDTH-1:0]   idx0_q, idx1_q;

  logic [ADDR_WIDTH-1:0]   rd_nat, rd_rev, rd_addr;
  logic                    issue, pop, push, busy, done;
  logic [2:0]              occ;

  assign rd_nat = rd_idx_q[ADDR_WIDTH-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < ADDR_WIDTH; gi++) begin : g_rev
      assign rd_rev[gi] = rd_nat[ADDR_WIDTH-1-gi];
    end
  endgenerate

  assign rd_addr = (BIT_REVERSE != 0) ? rd_rev : rd_nat;
  assign push    = inflight_q;
  assign pop     = (count_q != 2'd0) && i_ready;
  // Counting this cycle's pop as returned credit is what sustains one bin per cycle.
  assign occ     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy  = 1'b1;
        issue = (rd_idx_q < NB_C) && (occ < 3'd2);
        if (pop && (idx0_q == LAST_IDX)) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rd_idx_q   <= '0;
      inflight_q <= 1'b0;
      infl_idx_q <= '0;
      addr_q     <= '0;
      count_q    <= 2'd0;
      data0_q    <= '0;
      data1_q    <= '0;
      idx0_q     <= '0;
      idx1_q     <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (state_q == ST_IDLE && i_start) begin
        rd_idx_q <= '0;
      end else if (issue) begin
        rd_idx_q <= rd_idx_q + 1'b1;
      end
      if (issue) begin
        infl_idx_q <= rd_nat;
        addr_q     <= rd_addr;
      end
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            data0_q <= i_ram_data;
            idx0_q  <= infl_idx_q;
          end else begin
            data1_q <= i_ram_data;
            idx1_q  <= infl_idx_q;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          data0_q <= data1_q;
          idx0_q  <= idx1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            data0_q <= i_ram_data;
            idx0_q  <= infl_idx_q;
          end else begin
            data0_q <= data1_q;
            idx0_q  <= idx1_q;
            data1_q <= i_ram_data;
            idx1_q  <= infl_idx_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ram_addr  = issue ? rd_addr : addr_q;
  assign o_ram_wr_en = 1'b0;
  assign o_ram_data  = '0;
  assign o_valid     = (count_q != 2'd0);
  assign o_real      = data0_q[DATA_WIDTH-1:HALF_W];
  assign o_imag      = data0_q[HALF_W-1:0];
  assign o_index     = idx0_q;
  assign o_last      = o_valid && (idx0_q == LAST_IDX);
  assign o_busy      = busy;
  assign o_done      = done;

endmodule

// File: tb/tb_fft_result_streamer.sv
// Directed bench: a natural-order full-spectrum instance and a bit-reversed half-spectrum instance.
module tb_fft_result_streamer;

  logic clk;
  int checks;
  int failures;

  logic [47:0] mem [512];

  logic        rst_a, start_a, ready_a, wr_en_a, valid_a, last_a, busy_a, done_a;
  logic [8:0]  addr_a, index_a;
  logic [47:0] wdata_a, rdata_a;
  logic [23:0] real_a, imag_a;

  logic        rst_b, start_b, ready_b, wr_en_b, valid_b, last_b, busy_b, done_b;
  logic [8:0]  addr_b, index_b;
  logic [47:0] wdata_b, rdata_b;
  logic [23:0] real_b, imag_b;

  fft_result_streamer #(.DATA_WIDTH(48), .BUFFER_DEPTH(512), .ADDR_WIDTH(9),
                        .BIT_REVERSE(0), .HALF_SPECTRUM(0)) u_nat (
    .clk(clk), .reset(rst_a), .i_start(start_a), .o_ram_addr(addr_a),
    .o_ram_wr_en(wr_en_a), .o_ram_data(wdata_a), .i_ram_data(rdata_a),
    .o_valid(valid_a), .i_ready(ready_a), .o_real(real_a), .o_imag(imag_a),
    .o_index(index_a), .o_last(last_a), .o_busy(busy_a), .o_done(done_a));

  fft_result_streamer #(.DATA_WIDTH(48), .BUFFER_DEPTH(512), .ADDR_WIDTH(9),
                        .BIT_REVERSE(1), .HALF_SPECTRUM(1)) u_rev (
    .clk(clk), .reset(rst_b), .i_start(start_b), .o_ram_addr(addr_b),
    .o_ram_wr_en(wr_en_b), .o_ram_data(wdata_b), .i_ram_data(rdata_b),
    .o_valid(valid_b), .i_ready(ready_b), .o_real(real_b), .o_imag(imag_b),
    .o_index(index_b), .o_last(last_b), .o_busy(busy_b), .o_done(done_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read RAM model shared by both instances
  always @(posedge clk) begin
    rdata_a <= mem[addr_a];
    rdata_b <= mem[addr_b];
  end

  function automatic logic [8:0] rev9(input logic [8:0] v);
    logic [8:0] r;
    for (int i = 0; i < 9; i++) r[i] = v[8-i];
    return r;
  endfunction

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic pulse_start_b();
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    ready_a = 1'b0; ready_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({valid_a, busy_a, done_a, last_a, wr_en_a} !== 5'b0 || index_a !== 9'd0 || addr_a !== 9'd0) begin
      failures++;
      $display("FAIL reset_ctrl_a got v=%b b=%b d=%b l=%b we=%b idx=%0d addr=%0d required all 0",
               valid_a, busy_a, done_a, last_a, wr_en_a, index_a, addr_a);
    end
    checks++;
    if (real_a !== 24'd0 || imag_a !== 24'd0 || wdata_a !== 48'd0) begin
      failures++;
      $display("FAIL reset_data_a got re=%0d im=%0d wd=%0h required 0", real_a, imag_a, wdata_a);
    end
    checks++;
    if ({valid_b, busy_b, done_b, last_b, wr_en_b} !== 5'b0 || index_b !== 9'd0 || addr_b !== 9'd0) begin
      failures++;
      $display("FAIL reset_ctrl_b got v=%b b=%b d=%b l=%b we=%b idx=%0d addr=%0d required all 0",
               valid_b, busy_b, done_b, last_b, wr_en_b, index_b, addr_b);
    end
    checks++;
    if (real_b !== 24'd0 || imag_b !== 24'd0 || wdata_b !== 48'd0) begin
      failures++;
      $display("FAIL reset_data_b got re=%0d im=%0d wd=%0h required 0", real_b, imag_b, wdata_b);
    end
    rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk); #1;
    $display("scenario reset: outputs checked on both instances");
  endtask

  task automatic test_natural();
    int k;
    int done_cyc;
    k = 0; done_cyc = -1;
    pulse_start_a();
    for (int cyc = 0; cyc < 600 && done_cyc < 0; cyc++) begin
      ready_a = 1'b1; #1;
      if (done_a) done_cyc = cyc;
      if (valid_a) begin
        checks++;
        if (index_a !== 9'(k) || real_a !== 24'(k + 1000) || imag_a !== 24'(k)) begin
          failures++;
          $display("FAIL nat_bin k=%0d got idx=%0d re=%0d im=%0d required idx=%0d re=%0d im=%0d",
                   k, index_a, real_a, imag_a, k, k + 1000, k);
        end
        checks++;
        if (last_a !== (k == 511)) begin
          failures++;
          $display("FAIL nat_last k=%0d got %b required %b", k, last_a, (k == 511));
        end
        checks++;
        if (cyc != k + 2) begin
          failures++;
          $display("FAIL nat_timing k=%0d got cycle %0d required %0d", k, cyc, k + 2);
        end
        k++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (k != 512) begin
      failures++;
      $display("FAIL nat_count got %0d required 512", k);
    end
    checks++;
    if (done_cyc != 514) begin
      failures++;
      $display("FAIL nat_done_cycle got %0d required 514", done_cyc);
    end
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0 || wr_en_a !== 1'b0) begin
      failures++;
      $display("FAIL nat_after_done got done=%b busy=%b we=%b required 0 0 0", done_a, busy_a, wr_en_a);
    end
    $display("scenario natural: bins=%0d done_cycle=%0d", k, done_cyc);
  endtask

  task automatic test_bitrev_half();
    int k;
    int done_cyc;
    logic [8:0] r;
    k = 0; done_cyc = -1;
    pulse_start_b();
    for (int cyc = 0; cyc < 400 && done_cyc < 0; cyc++) begin
      ready_b = 1'b1; #1;
      if (done_b) done_cyc = cyc;
      if (valid_b) begin
        r = rev9(9'(k));
        checks++;
        if (index_b !== 9'(k) || imag_b !== 24'(r) || real_b !== 24'(r) + 24'd1000) begin
          failures++;
          $display("FAIL rev_bin k=%0d got idx=%0d re=%0d im=%0d required idx=%0d re=%0d im=%0d",
                   k, index_b, real_b, imag_b, k, r + 1000, r);
        end
        if (k == 1) begin
          checks++;
          if (imag_b !== 24'd256) begin
            failures++;
            $display("FAIL rev_idx1 got im=%0d required 256", imag_b);
          end
        end
        if (k == 2) begin
          checks++;
          if (imag_b !== 24'd128) begin
            failures++;
            $display("FAIL rev_idx2 got im=%0d required 128", imag_b);
          end
        end
        checks++;
        if (last_b !== (k == 255)) begin
          failures++;
          $display("FAIL rev_last k=%0d got %b required %b", k, last_b, (k == 255));
        end
        k++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (k != 256) begin
      failures++;
      $display("FAIL rev_count got %0d required 256", k);
    end
    checks++;
    if (done_cyc != 258) begin
      failures++;
      $display("FAIL rev_done_cycle got %0d required 258", done_cyc);
    end
    $display("scenario bitrev_half: bins=%0d done_cycle=%0d", k, done_cyc);
  endtask

  task automatic test_backpressure();
    int k;
    int done_cyc;
    logic stalled;
    logic [8:0] p_idx;
    logic [23:0] p_re, p_im;
    logic p_last;
    logic [8:0] r;
    k = 0; done_cyc = -1; stalled = 1'b0;
    p_idx = '0; p_re = '0; p_im = '0; p_last = 1'b0;
    pulse_start_b();
    for (int cyc = 0; cyc < 2000 && done_cyc < 0; cyc++) begin
      ready_b = (cyc % 3 == 0) && ($urandom_range(0, 4) != 0);
      #1;
      if (done_b) done_cyc = cyc;
      if (stalled) begin
        checks++;
        if (valid_b !== 1'b1 || index_b !== p_idx || real_b !== p_re || imag_b !== p_im || last_b !== p_last) begin
          failures++;
          $display("FAIL bp_stable got v=%b idx=%0d re=%0d im=%0d l=%b required v=1 idx=%0d re=%0d im=%0d l=%b",
                   valid_b, index_b, real_b, imag_b, last_b, p_idx, p_re, p_im, p_last);
        end
      end
      if (valid_b && ready_b) begin
        r = rev9(9'(k));
        checks++;
        if (index_b !== 9'(k) || imag_b !== 24'(r) || real_b !== 24'(r) + 24'd1000) begin
          failures++;
          $display("FAIL bp_bin k=%0d got idx=%0d re=%0d im=%0d required idx=%0d re=%0d im=%0d",
                   k, index_b, real_b, imag_b, k, r + 1000, r);
        end
        k++;
      end
      stalled = valid_b && !ready_b;
      p_idx = index_b; p_re = real_b; p_im = imag_b; p_last = last_b;
      @(posedge clk); #1;
    end
    checks++;
    if (k != 256 || done_cyc < 0) begin
      failures++;
      $display("FAIL bp_complete got bins=%0d done_cycle=%0d required bins=256 and a done pulse", k, done_cyc);
    end
    $display("scenario backpressure: bins=%0d done_cycle=%0d", k, done_cyc);
  endtask

  task automatic test_stall_start();
    int k;
    int done_cyc;
    int last_acc;
    k = 0; done_cyc = -1; last_acc = -1;
    pulse_start_a();
    for (int cyc = 0; cyc < 700 && done_cyc < 0; cyc++) begin
      ready_a = (cyc >= 10);
      #1;
      if (done_a) done_cyc = cyc;
      if (cyc < 10) begin
        checks++;
        if (addr_a !== ((cyc == 0) ? 9'd0 : 9'd1)) begin
          failures++;
          $display("FAIL stall_addr cycle=%0d got %0d required %0d", cyc, addr_a, (cyc == 0) ? 0 : 1);
        end
      end
      if (cyc == 9) begin
        checks++;
        if (valid_a !== 1'b1 || index_a !== 9'd0) begin
          failures++;
          $display("FAIL stall_head got v=%b idx=%0d required v=1 idx=0", valid_a, index_a);
        end
      end
      if (valid_a && ready_a) begin
        checks++;
        if (index_a !== 9'(k) || imag_a !== 24'(k) || (last_acc >= 0 && cyc - last_acc > 2)) begin
          failures++;
          $display("FAIL stall_flow k=%0d cycle=%0d got idx=%0d im=%0d prev_accept=%0d required idx=%0d gap<=2",
                   k, cyc, index_a, imag_a, last_acc, k);
        end
        last_acc = cyc;
        k++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (k != 512 || done_cyc < 0) begin
      failures++;
      $display("FAIL stall_complete got bins=%0d done_cycle=%0d required bins=512 and a done pulse", k, done_cyc);
    end
    $display("scenario stall_start: bins=%0d done_cycle=%0d", k, done_cyc);
  endtask

  task automatic test_restart_ignored();
    int k;
    int done_cyc;
    int done_cnt;
    k = 0; done_cyc = -1; done_cnt = 0;
    pulse_start_a();
    for (int cyc = 0; cyc < 540; cyc++) begin
      ready_a = 1'b1; start_a = 1'b0;
      #1;
      if (done_a) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (valid_a) begin
        checks++;
        if (index_a !== 9'(k) || imag_a !== 24'(k)) begin
          failures++;
          $display("FAIL restart_bin k=%0d got idx=%0d im=%0d required idx=%0d im=%0d", k, index_a, imag_a, k, k);
        end
        if (index_a == 9'd100) start_a = 1'b1;
        k++;
      end
      @(posedge clk); #1;
    end
    start_a = 1'b0;
    checks++;
    if (done_cnt != 1 || done_cyc != 514 || k != 512) begin
      failures++;
      $display("FAIL restart_done got pulses=%0d cycle=%0d bins=%0d required 1 514 512", done_cnt, done_cyc, k);
    end
    checks++;
    if (busy_a !== 1'b0) begin
      failures++;
      $display("FAIL restart_idle got busy=%b required 0", busy_a);
    end
    $display("scenario restart_ignored: bins=%0d done_pulses=%0d", k, done_cnt);
  endtask

  task automatic test_reset_mid();
    int k;
    int done_cyc;
    logic hit;
    logic [8:0] r;
    hit = 1'b0;
    pulse_start_b();
    for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
      ready_b = 1'b1; #1;
      if (valid_b && index_b == 9'd50) begin
        ready_b = 1'b0;
        hit = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL rmid_reach got no bin 50 required bin 50 within 200 cycles");
    end
    repeat (3) begin
      @(posedge clk); #2;
      checks++;
      if (valid_b !== 1'b1 || index_b !== 9'd50) begin
        failures++;
        $display("FAIL rmid_stall got v=%b idx=%0d required v=1 idx=50", valid_b, index_b);
      end
    end
    rst_b = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (valid_b !== 1'b0 || busy_b !== 1'b0 || done_b !== 1'b0 || index_b !== 9'd0) begin
      failures++;
      $display("FAIL rmid_reset got v=%b b=%b d=%b idx=%0d required 0 0 0 0", valid_b, busy_b, done_b, index_b);
    end
    rst_b = 1'b0;
    @(posedge clk); #1;
    k = 0; done_cyc = -1;
    pulse_start_b();
    for (int cyc = 0; cyc < 400 && done_cyc < 0; cyc++) begin
      ready_b = 1'b1; #1;
      if (done_b) done_cyc = cyc;
      if (valid_b) begin
        r = rev9(9'(k));
        checks++;
        if (index_b !== 9'(k) || imag_b !== 24'(r) || real_b !== 24'(r) + 24'd1000) begin
          failures++;
          $display("FAIL rmid_bin k=%0d got idx=%0d re=%0d im=%0d required idx=%0d re=%0d im=%0d",
                   k, index_b, real_b, imag_b, k, r + 1000, r);
        end
        k++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (k != 256 || done_cyc != 258) begin
      failures++;
      $display("FAIL rmid_restart got bins=%0d done_cycle=%0d required 256 258", k, done_cyc);
    end
    $display("scenario reset_mid: restart bins=%0d done_cycle=%0d", k, done_cyc);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int a = 0; a < 512; a++) mem[a] = {24'(a + 1000), 24'(a)};
    test_reset();
    test_natural();
    test_bitrev_half();
    test_backpressure();
    test_stall_start();
    test_restart_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_result_streamer.md
Name: fft_result_streamer

Overview:
- Reads completed FFT results out of the 512x48 working RAM through one RAM port and streams them as a valid/ready sequence of bins to the downstream magnitude/display path.
- Sits between the working RAM and the spectrum post-processing chain. Acts as the read-side consumer of the RAM once the butterfly engine has finished.
- Handles the RAM's 1-cycle registered read latency, optional bit-reversed addressing and downstream backpressure without losing or duplicating words.

Parameters:
- DATA_WIDTH, 48, RAM word width: real in [DATA_WIDTH-1:DATA_WIDTH/2], imaginary in [DATA_WIDTH/2-1:0], both two's complement.
- BUFFER_DEPTH, 512, FFT size N in words; power of two, at least 4.
- ADDR_WIDTH, 9, log2(BUFFER_DEPTH).
- BIT_REVERSE, 1, 1 = RAM address is the bit-reversed bin index; 0 = natural order.
- HALF_SPECTRUM, 1, 1 = stream bins 0..N/2-1 only; 0 = stream bins 0..N-1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- i_start  input  1  one-cycle pulse that begins a frame readout.
- o_ram_addr  output  ADDR_WIDTH  read address to the RAM port.
- o_ram_wr_en  output  1  RAM write enable; held at 0.
- o_ram_data  output  DATA_WIDTH  RAM write data; held at 0.
- i_ram_data  input  DATA_WIDTH  registered RAM read data; valid 1 cycle after the address.
- o_valid  output  1  output bin valid.
- i_ready  input  1  downstream accepts the bin when o_valid and i_ready are both 1 at a rising edge.
- o_real  output  DATA_WIDTH/2  real part of the bin.
- o_imag  output  DATA_WIDTH/2  imaginary part of the bin.
- o_index  output  ADDR_WIDTH  natural-order bin index.
- o_last  output  1  marks the final bin of the frame; qualified by o_valid.
- o_busy  output  1  frame in progress.
- o_done  output  1  one-cycle pulse after the final bin is accepted.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; FIFO empty; all counters 0. Reset mid-frame aborts immediately and discards any in-flight data.
- Bin count: NB = N/2 if HALF_SPECTRUM = 1, else N.

FSM:
- IDLE: o_busy = 0. On i_start, go to RUN. Read counter rd_idx = 0 and output counter out_idx = 0.
- RUN: o_busy = 1.
  - Issue a read whenever rd_idx < NB and (fifo_count + inflight) < 2.
  - o_ram_addr = bitrev(rd_idx) when BIT_REVERSE = 1, else rd_idx.
  - rd_idx increments on each issued read.
  - inflight is a 1-bit flag set on issue. On the following cycle it clears and i_ram_data is pushed into the FIFO together with its natural index.
  - When the final bin (index NB-1) is accepted, go to DONE.
- DONE: o_done = 1 for exactly one cycle, o_busy = 0, then return to IDLE.
- i_start is ignored in RUN and DONE.

Output FIFO:
- 2-entry FIFO holding {data, index}; the head drives o_real, o_imag, o_index and o_last.
- o_valid = FIFO not empty.
- o_last = o_valid and (head index == NB-1).
- A push and a pop in the same cycle are both honoured.
- The FIFO never overflows, because the credit rule counts the in-flight read.
- While o_valid = 1 and i_ready = 0, o_real, o_imag, o_index and o_last hold stable.

Throughput and latency:
- With i_ready held at 1: first o_valid appears 2 cycles after the i_start edge (issue, then RAM latency), then 1 bin per cycle.
- Total frame time is NB+2 cycles to o_done.

Other rules:
- o_ram_addr holds its last value when no read is issued. Reads are side-effect free.
- bitrev is applied over the full ADDR_WIDTH bits, e.g. N=512: index 1 -> address 256, index 3 -> address 384.

Test Plan:
- Preload the RAM model with word[a] = {24'(a+1000), 24'(a)}. Use BIT_REVERSE=0, HALF_SPECTRUM=0, i_ready=1, and pulse i_start.
  - Required: bins 0..511 appear consecutively, bin k has o_real = k+1000 and o_imag = k.
  - o_last only on index 511; o_done 514 cycles after start.
- BIT_REVERSE=1, HALF_SPECTRUM=1, same preload.
  - Required: 256 bins; index 1 carries o_imag = 256 and index 2 carries o_imag = 128.
  - o_last on index 255.
- Backpressure: toggle i_ready with a 1-on/2-off pattern, plus random holds.
  - Required: no bin is lost or duplicated, indices arrive strictly increasing.
  - Outputs stay stable while stalled, and the FIFO never exceeds 2 entries.
- Hold i_ready=0 from start for 10 cycles.
  - Required: exactly 2 reads are issued and o_ram_addr stops advancing.
  - On release, bins 0,1,2,... flow with no gap beyond the 1-cycle refill.
- Pulse i_start again mid-frame at bin 100.
  - Required: ignored; the frame completes normally with a single o_done.
- Assert reset at bin 50 during a stall.
  - Required: next cycle o_valid, o_busy and o_done are 0 and o_index = 0.
  - A fresh i_start restarts from index 0 with correct data.
